// File: rtl/axi_write_arbiter.sv
// Write-path arbiter/decoder for the 2-master, 4-slave AXI interconnect.
// Grants one AW request round-robin, decodes the slave, and tracks the burst to its B handshake.
module axi_write_arbiter #(
  parameter logic [31:0] S1_BASE = 32'h0001_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S2_BASE = 32'h0002_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S3_BASE = 32'h1000_0000,
  parameter logic [31:0] S3_MASK = 32'hFFFF_FC00,
  parameter logic [31:0] S4_BASE = 32'h2000_0000,
  parameter logic [31:0] S4_MASK = 32'hFFE0_0000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        AWVALID_M0,
  input  logic        AWVALID_M1,
  input  logic [31:0] AWADDR_M0,
  input  logic [31:0] AWADDR_M1,
  input  logic [3:0]  AWLEN_M0,
  input  logic [3:0]  AWLEN_M1,
  input  logic        AWREADY_M0,
  input  logic        AWREADY_M1,
  input  logic        WVALID_M0,
  input  logic        WVALID_M1,
  input  logic        WLAST_M0,
  input  logic        WLAST_M1,
  input  logic        WREADY_M0,
  input  logic        WREADY_M1,
  input  logic        BVALID_M0,
  input  logic        BVALID_M1,
  input  logic        BREADY_M0,
  input  logic        BREADY_M1,
  output logic [1:0]  write_state_ctrl,
  output logic [3:0]  awid_ctrl,
  output logic        len_err
);

  typedef enum logic [1:0] {StIdle = 2'b00, StData = 2'b01, StResp = 2'b10} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        mst_q, mst_d;
  logic [2:0]  slv_q, slv_d;
  logic [3:0]  len_q, len_d;
  logic [4:0]  beat_q, beat_d;
  logic        len_err_q, len_err_d;

  logic        req_any, grant, grant_ready;
  logic [31:0] grant_addr;
  logic [3:0]  grant_len;
  logic [2:0]  grant_slv;
  logic        w_hs, w_last, b_hs;
  logic [4:0]  beat_inc, beats_exp;

  function automatic logic [2:0] decode(input logic [31:0] addr);
    if ((addr & S1_MASK) == S1_BASE) return 3'd1;
    else if ((addr & S2_MASK) == S2_BASE) return 3'd2;
    else if ((addr & S3_MASK) == S3_BASE) return 3'd3;
    else if ((addr & S4_MASK) == S4_BASE) return 3'd4;
    else return 3'd7;
  endfunction

  assign req_any     = AWVALID_M0 | AWVALID_M1;
  // On a tie the master that did not win last time is granted.
  assign grant       = (AWVALID_M0 & AWVALID_M1) ? ~last_grant_q : AWVALID_M1;
  assign grant_addr  = grant ? AWADDR_M1 : AWADDR_M0;
  assign grant_len   = grant ? AWLEN_M1 : AWLEN_M0;
  assign grant_ready = grant ? AWREADY_M1 : AWREADY_M0;
  assign grant_slv   = decode(grant_addr);

  assign w_hs      = mst_q ? (WVALID_M1 & WREADY_M1) : (WVALID_M0 & WREADY_M0);
  assign w_last    = mst_q ? WLAST_M1 : WLAST_M0;
  assign b_hs      = mst_q ? (BVALID_M1 & BREADY_M1) : (BVALID_M0 & BREADY_M0);
  assign beat_inc  = (beat_q == 5'd31) ? beat_q : beat_q + 5'd1;
  assign beats_exp = {1'b0, len_q} + 5'd1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mst_d        = mst_q;
    slv_d        = slv_q;
    len_d        = len_q;
    beat_d       = beat_q;
    len_err_d    = len_err_q;
    awid_ctrl    = {mst_q, slv_q};
    unique case (state_q)
      StIdle: begin
        awid_ctrl = (req_any && ARESETn) ? {grant, grant_slv} : 4'b0000;
        if (req_any && grant_ready) begin
          mst_d        = grant;
          slv_d        = grant_slv;
          len_d        = grant_len;
          beat_d       = 5'd0;
          last_grant_d = grant;
          state_d      = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          beat_d = beat_inc;
          if (w_last) begin
            state_d = StResp;
            if (beat_inc != beats_exp) len_err_d = 1'b1;
          end else if (beat_inc > {1'b0, len_q}) begin
            len_err_d = 1'b1;
          end
        end
      end
      StResp: begin
        if (b_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      mst_q        <= 1'b0;
      slv_q        <= 3'd0;
      len_q        <= 4'd0;
      beat_q       <= 5'd0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mst_q        <= mst_d;
      slv_q        <= slv_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      len_err_q    <= len_err_d;
    end
  end

  assign write_state_ctrl = state_q;
  assign len_err          = len_err_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Randomized self-checking bench for axi_write_arbiter against a transaction-level model.
module tb_axi_write_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID_M0, AWVALID_M1, AWREADY_M0, AWREADY_M1;
  logic [31:0] AWADDR_M0, AWADDR_M1;
  logic [3:0]  AWLEN_M0, AWLEN_M1;
  logic        WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1, WREADY_M0, WREADY_M1;
  logic        BVALID_M0, BVALID_M1, BREADY_M0, BREADY_M1;
  logic [1:0]  write_state_ctrl;
  logic [3:0]  awid_ctrl;
  logic        len_err;

  int checks = 0;
  int errors = 0;

  axi_write_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID_M0(AWVALID_M0), .AWVALID_M1(AWVALID_M1),
    .AWADDR_M0(AWADDR_M0), .AWADDR_M1(AWADDR_M1),
    .AWLEN_M0(AWLEN_M0), .AWLEN_M1(AWLEN_M1),
    .AWREADY_M0(AWREADY_M0), .AWREADY_M1(AWREADY_M1),
    .WVALID_M0(WVALID_M0), .WVALID_M1(WVALID_M1),
    .WLAST_M0(WLAST_M0), .WLAST_M1(WLAST_M1),
    .WREADY_M0(WREADY_M0), .WREADY_M1(WREADY_M1),
    .BVALID_M0(BVALID_M0), .BVALID_M1(BVALID_M1),
    .BREADY_M0(BREADY_M0), .BREADY_M1(BREADY_M1),
    .write_state_ctrl(write_state_ctrl), .awid_ctrl(awid_ctrl), .len_err(len_err)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: address map table, last winner, sticky length error.
  logic [31:0] base_t [4] = '{32'h0001_0000, 32'h0002_0000, 32'h1000_0000, 32'h2000_0000};
  logic [31:0] mask_t [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FC00, 32'hFFE0_0000};
  int m_last = 1;
  bit m_lenerr = 1'b0;

  function automatic logic [2:0] exp_slave(input logic [31:0] a);
    for (int n = 0; n < 4; n++) if ((a & mask_t[n]) == base_t[n]) return 3'(n + 1);
    return 3'd7;
  endfunction

  function automatic int exp_grant(input bit v0, input bit v1);
    if (v0 && v1) return 1 - m_last;
    return v1 ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    {AWVALID_M0, AWVALID_M1, AWREADY_M0, AWREADY_M1} = '0;
    {AWADDR_M0, AWADDR_M1, AWLEN_M0, AWLEN_M1} = '0;
    {WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1, WREADY_M0, WREADY_M1} = '0;
    {BVALID_M0, BVALID_M1, BREADY_M0, BREADY_M1} = '0;
  endtask

  task automatic set_aw(input int m, input logic v, input logic [31:0] a, input logic [3:0] l,
                        input logic rdy);
    if (m == 0) begin AWVALID_M0 = v; AWADDR_M0 = a; AWLEN_M0 = l; AWREADY_M0 = rdy; end
    else        begin AWVALID_M1 = v; AWADDR_M1 = a; AWLEN_M1 = l; AWREADY_M1 = rdy; end
  endtask

  task automatic set_w(input int m, input logic v, input logic last, input logic rdy);
    if (m == 0) begin WVALID_M0 = v; WLAST_M0 = last; WREADY_M0 = rdy; end
    else        begin WVALID_M1 = v; WLAST_M1 = last; WREADY_M1 = rdy; end
  endtask

  task automatic set_b(input int m, input logic v, input logic rdy);
    if (m == 0) begin BVALID_M0 = v; BREADY_M0 = rdy; end
    else        begin BVALID_M1 = v; BREADY_M1 = rdy; end
  endtask

  task automatic apply_reset();
    ARESETn = 1'b0;
    idle_inputs();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    m_last   = 1;
    m_lenerr = 1'b0;
    tick();
  endtask

  // From DATA: send nbeats beats (WLAST on the final one), then the B handshake.
  task automatic finish_txn(input int m, input int nbeats);
    for (int b = 1; b <= nbeats; b++) begin
      set_w(m, 1'b1, b == nbeats, 1'b1);
      tick();
    end
    set_w(m, 1'b0, 1'b0, 1'b0);
    set_b(m, 1'b1, 1'b1);
    tick();
    set_b(m, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    idle_inputs();
    #3;
    checks++; if (write_state_ctrl !== 2'b00) begin errors++;
      $display("FAIL reset_state got=%b exp=00", write_state_ctrl); end
    checks++; if (awid_ctrl !== 4'b0000) begin errors++;
      $display("FAIL reset_awid got=%b exp=0000", awid_ctrl); end
    checks++; if (len_err !== 1'b0) begin errors++;
      $display("FAIL reset_len_err got=%b exp=0", len_err); end
    @(negedge ACLK);
    ARESETn = 1'b1;
    m_last = 1; m_lenerr = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    set_aw(0, 1'b1, 32'h0001_0000, 4'd0, 1'b1);
    set_aw(1, 1'b1, 32'h0002_0000, 4'd0, 1'b1);
    #1;
    checks++; if (awid_ctrl !== 4'b0001) begin errors++;
      $display("FAIL rr_first got=%b exp=0001", awid_ctrl); end
    tick(); m_last = 0;
    set_aw(0, 1'b0, 32'h0, 4'd0, 1'b0);
    finish_txn(0, 1);
    set_aw(0, 1'b1, 32'h0001_0000, 4'd0, 1'b1);
    #1;
    checks++; if (awid_ctrl !== 4'b1010) begin errors++;
      $display("FAIL rr_second got=%b exp=1010", awid_ctrl); end
    tick(); m_last = 1;
    idle_inputs();
    checks++; if (awid_ctrl !== 4'b1010 || write_state_ctrl !== 2'b01) begin errors++;
      $display("FAIL rr_latched got=%b/%b exp=1010/01", awid_ctrl, write_state_ctrl); end
    finish_txn(1, 1);
  endtask

  task automatic test_basic();
    set_aw(0, 1'b1, 32'h0002_0040, 4'd3, 1'b1);
    #1;
    checks++; if (awid_ctrl !== 4'b0010) begin errors++;
      $display("FAIL basic_awid got=%b exp=0010", awid_ctrl); end
    tick(); m_last = 0;
    set_aw(0, 1'b0, 32'h0, 4'd0, 1'b0);
    checks++; if (write_state_ctrl !== 2'b01) begin errors++;
      $display("FAIL basic_data got=%b exp=01", write_state_ctrl); end
    for (int i = 0; i < 4; i++) begin
      set_w(0, 1'b1, i == 3, 1'b1);
      tick();
      checks++; if (write_state_ctrl !== ((i == 3) ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL basic_beat%0d got=%b exp=%b", i, write_state_ctrl, (i == 3) ? 2'b10 : 2'b01); end
    end
    set_w(0, 1'b0, 1'b0, 1'b0);
    set_b(0, 1'b1, 1'b1);
    tick();
    set_b(0, 1'b0, 1'b0);
    checks++; if (write_state_ctrl !== 2'b00 || len_err !== 1'b0) begin errors++;
      $display("FAIL basic_done got=%b/%b exp=00/0", write_state_ctrl, len_err); end
  endtask

  task automatic test_decode();
    logic [31:0] addrs [3] = '{32'h1000_0010, 32'h2010_0000, 32'h3000_0000};
    logic [3:0]  exps  [3] = '{4'b1011, 4'b1100, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      set_aw(1, 1'b1, addrs[i], 4'd0, 1'b1);
      #1;
      checks++; if (awid_ctrl !== exps[i]) begin errors++;
        $display("FAIL decode_%h got=%b exp=%b", addrs[i], awid_ctrl, exps[i]); end
      tick(); m_last = 1;
      set_aw(1, 1'b0, 32'h0, 4'd0, 1'b0);
      finish_txn(1, 1);
    end
  endtask

  task automatic test_ignore_other();
    set_aw(0, 1'b1, 32'h2000_0100, 4'd1, 1'b1);
    tick(); m_last = 0;
    set_aw(0, 1'b0, 32'h0, 4'd0, 1'b0);
    set_aw(1, 1'b1, 32'h0001_0000, 4'd0, 1'b1);
    set_w(1, 1'b1, 1'b1, 1'b1);
    set_b(1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      set_w(0, 1'b1, i == 1, 1'b1);
      tick();
      checks++; if (awid_ctrl !== 4'b0100 || write_state_ctrl !== ((i == 1) ? 2'b10 : 2'b01))
        begin errors++;
        $display("FAIL ignore_beat%0d got=%b/%b exp=0100/%b", i, awid_ctrl, write_state_ctrl,
                 (i == 1) ? 2'b10 : 2'b01); end
    end
    set_w(0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (awid_ctrl !== 4'b0100 || write_state_ctrl !== 2'b10) begin errors++;
      $display("FAIL ignore_resp got=%b/%b exp=0100/10", awid_ctrl, write_state_ctrl); end
    set_b(0, 1'b1, 1'b1);
    tick();
    set_b(0, 1'b0, 1'b0);
    set_w(1, 1'b0, 1'b0, 1'b0);
    set_b(1, 1'b0, 1'b0);
    checks++; if (awid_ctrl !== 4'b1001 || write_state_ctrl !== 2'b00) begin errors++;
      $display("FAIL ignore_regrant got=%b/%b exp=1001/00", awid_ctrl, write_state_ctrl); end
    tick(); m_last = 1;
    set_aw(1, 1'b0, 32'h0, 4'd0, 1'b0);
    finish_txn(1, 1);
  endtask

  task automatic test_len_err();
    apply_reset();
    set_aw(0, 1'b1, 32'h0002_0000, 4'd1, 1'b1);
    tick(); m_last = 0;
    set_aw(0, 1'b0, 32'h0, 4'd0, 1'b0);
    set_w(0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (len_err !== 1'b0) begin errors++;
      $display("FAIL overrun_early got=%b exp=0", len_err); end
    tick();
    checks++; if (len_err !== 1'b1 || write_state_ctrl !== 2'b01) begin errors++;
      $display("FAIL overrun got=%b/%b exp=1/01", len_err, write_state_ctrl); end
    finish_txn(0, 1);
    apply_reset();
    set_aw(0, 1'b1, 32'h0001_0000, 4'd3, 1'b1);
    tick(); m_last = 0;
    set_aw(0, 1'b0, 32'h0, 4'd0, 1'b0);
    set_w(0, 1'b1, 1'b0, 1'b1); tick();
    set_w(0, 1'b1, 1'b1, 1'b1); tick();
    set_w(0, 1'b0, 1'b0, 1'b0);
    checks++; if (len_err !== 1'b1 || write_state_ctrl !== 2'b10) begin errors++;
      $display("FAIL short_last got=%b/%b exp=1/10", len_err, write_state_ctrl); end
    set_b(0, 1'b1, 1'b1); tick(); set_b(0, 1'b0, 1'b0);
    set_aw(1, 1'b1, 32'h0002_0000, 4'd2, 1'b1);
    tick(); m_last = 1;
    set_aw(1, 1'b0, 32'h0, 4'd0, 1'b0);
    finish_txn(1, 3);
    checks++; if (len_err !== 1'b1) begin errors++;
      $display("FAIL len_err_sticky got=%b exp=1", len_err); end
  endtask

  task automatic test_random();
    logic [31:0] addr [2];
    logic [3:0]  len  [2];
    bit v0, v1;
    int g, nbeats;
    logic [3:0] exp_id;
    apply_reset();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_inputs();
        #1;
        checks++; if (awid_ctrl !== 4'b0000) begin errors++;
          $display("FAIL rand_noreq got=%b exp=0000", awid_ctrl); end
        tick();
      end
      for (int m = 0; m < 2; m++) begin
        case ($urandom_range(0, 4))
          0, 1, 2, 3: addr[m] = base_t[$urandom_range(0, 3)] + ($urandom & 32'h0000_03FF);
          default:    addr[m] = $urandom;
        endcase
        len[m] = 4'($urandom_range(0, 7));
      end
      do begin v0 = 1'($urandom); v1 = 1'($urandom); end while (!(v0 || v1));
      g = exp_grant(v0, v1);
      exp_id = {g[0], exp_slave(addr[g])};
      set_aw(0, v0, addr[0], len[0], 1'b0);
      set_aw(1, v1, addr[1], len[1], 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        tick();
        checks++; if (write_state_ctrl !== 2'b00) begin errors++;
          $display("FAIL rand_stall got=%b exp=00", write_state_ctrl); end
      end
      AWREADY_M0 = 1'b1; AWREADY_M1 = 1'b1;
      #1;
      checks++; if (awid_ctrl !== exp_id) begin errors++;
        $display("FAIL rand_grant%0d got=%b exp=%b", it, awid_ctrl, exp_id); end
      tick();
      m_last = g;
      set_aw(g, 1'b0, 32'h0, 4'd0, 1'b1);
      nbeats = int'(len[g]) + 1;
      if ($urandom_range(0, 4) == 0) nbeats = $urandom_range(1, int'(len[g]) + 3);
      for (int b = 1; b <= nbeats; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          set_w(g, 1'b0, 1'b1, 1'b1);
          set_w(1 - g, 1'($urandom), 1'($urandom), 1'($urandom));
          tick();
        end
        set_w(g, 1'b1, b == nbeats, 1'b1);
        set_w(1 - g, 1'($urandom), 1'($urandom), 1'($urandom));
        tick();
        checks++; if (write_state_ctrl !== ((b == nbeats) ? 2'b10 : 2'b01) || awid_ctrl !== exp_id)
          begin errors++;
          $display("FAIL rand_beat%0d_%0d got=%b/%b exp=%b/%b", it, b, write_state_ctrl, awid_ctrl,
                   (b == nbeats) ? 2'b10 : 2'b01, exp_id); end
      end
      set_w(0, 1'b0, 1'b0, 1'b0); set_w(1, 1'b0, 1'b0, 1'b0);
      if (nbeats != int'(len[g]) + 1) m_lenerr = 1'b1;
      checks++; if (len_err !== m_lenerr) begin errors++;
        $display("FAIL rand_len_err%0d got=%b exp=%b", it, len_err, m_lenerr); end
      set_b(1 - g, 1'b1, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
      set_b(g, 1'b1, 1'b1);
      tick();
      idle_inputs();
      checks++; if (write_state_ctrl !== 2'b00) begin errors++;
        $display("FAIL rand_done%0d got=%b exp=00", it, write_state_ctrl); end
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    set_aw(0, 1'b1, 32'h0001_0000, 4'd0, 1'b1);
    tick();
    set_aw(0, 1'b0, 32'h0, 4'd0, 1'b0);
    set_w(0, 1'b1, 1'b0, 1'b1);
    tick();
    set_w(0, 1'b0, 1'b0, 1'b0);
    checks++; if (len_err !== 1'b1 || write_state_ctrl !== 2'b01) begin errors++;
      $display("FAIL async_pre got=%b/%b exp=1/01", len_err, write_state_ctrl); end
    #1 ARESETn = 1'b0;
    #1;
    checks++; if (write_state_ctrl !== 2'b00 || awid_ctrl !== 4'b0000 || len_err !== 1'b0)
      begin errors++;
      $display("FAIL async_reset got=%b/%b/%b exp=00/0000/0", write_state_ctrl, awid_ctrl, len_err);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    m_last = 1; m_lenerr = 1'b0;
    tick();
    set_aw(0, 1'b1, 32'h0002_0000, 4'd0, 1'b0);
    set_aw(1, 1'b1, 32'h0001_0000, 4'd0, 1'b0);
    #1;
    checks++; if (write_state_ctrl !== 2'b00 || awid_ctrl !== 4'b0010) begin errors++;
      $display("FAIL async_after got=%b/%b exp=00/0010", write_state_ctrl, awid_ctrl); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_basic();
    test_decode();
    test_ignore_other();
    test_len_err();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
